// File: rtl/hls_handshake_monitor.sv
// hls_handshake_monitor
//   Status monitor for a single non-dataflow HLS block-level handshake
//   (ap_start/ap_ready/ap_done/ap_continue). It counts accepted and completed
//   transactions and measures per-transaction latency. It also counts busy
//   cycles and done-stall cycles, and reports a coarse status. Once a finish
//   request is sampled, every result freezes until reset.
//
//   Optional build macro: HLS_MON_TIMEOUT_EN
//     Adds parameter TIMEOUT and the sticky output err_timeout. err_timeout
//     sets when the oldest outstanding transaction has been pending for
//     TIMEOUT cycles.
//
//   Ports
//     clock        rising-edge clock
//     reset        asynchronous active-low reset
//     ap_start     monitored start
//     ap_ready     monitored ready
//     ap_done      monitored done
//     ap_continue  monitored continue (tie high if the block has none)
//     finish       freeze request
//     status       0=IDLE 1=ACTIVE 2=STALL 3=FINISHED
//     txn_in_cnt   accepted transactions (saturating)
//     txn_out_cnt  completed transactions, including underflows (saturating)
//     lat_valid    one-cycle pulse when last_lat updates
//     last_lat     latency of the most recent completion
//     min_lat      minimum latency seen (all ones until the first completion)
//     max_lat      maximum latency seen
//     busy_cycles  cycles with at least one outstanding transaction (saturating)
//     stall_cycles cycles with ap_done=1 and ap_continue=0 (saturating)
//     err_ovf      sticky: accept while the timestamp FIFO was full
//     err_unf      sticky: completion with nothing outstanding
module hls_handshake_monitor #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned DEPTH = 4
`ifdef HLS_MON_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = 1000
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_continue,
    input  logic             finish,
    output logic [1:0]       status,
    output logic [CNT_W-1:0] txn_in_cnt,
    output logic [CNT_W-1:0] txn_out_cnt,
    output logic             lat_valid,
    output logic [CNT_W-1:0] last_lat,
    output logic [CNT_W-1:0] min_lat,
    output logic [CNT_W-1:0] max_lat,
    output logic [CNT_W-1:0] busy_cycles,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             err_ovf,
    output logic             err_unf
`ifdef HLS_MON_TIMEOUT_EN
    ,
    output logic             err_timeout
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_STALL    = 2'd2,
        ST_FINISHED = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] ts;
    logic [CNT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;

    logic             accept;
    logic             complete;
    logic             stall_now;
    logic             empty;
    logic             full;
    logic             pop;
    logic             zero_lat;
    logic             unf;
    logic             push_req;
    logic             push;
    logic             ovf;
    logic             lat_upd;
    logic [CNT_W-1:0] lat;
    logic [CNT_W-1:0] lat_new;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    always_comb begin
        accept    = ap_start & ap_ready;
        complete  = ap_done & ap_continue;
        stall_now = ap_done & ~ap_continue;
        empty     = (count == '0);
        full      = (count == CW'(DEPTH));
        pop       = complete & ~empty;
        // With nothing outstanding, a same-cycle accept is consumed by the
        // completion as a zero-latency transaction and never enters the FIFO.
        zero_lat  = complete & empty & accept;
        unf       = complete & empty & ~accept;
        push_req  = accept & ~zero_lat;
        // Pop happens before push, so a full FIFO that also pops has room.
        ovf       = push_req & full & ~pop;
        push      = push_req & ~ovf;
        // Modular subtraction keeps the latency correct across timestamp wrap.
        lat       = ts - mem[rd_ptr];
        lat_new   = pop ? lat : '0;
        lat_upd   = pop | zero_lat;
    end

    always_ff @(posedge clock) begin
        if (push && (state != ST_FINISHED)) begin
            mem[wr_ptr] <= ts;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            ts           <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            txn_in_cnt   <= '0;
            txn_out_cnt  <= '0;
            lat_valid    <= 1'b0;
            last_lat     <= '0;
            min_lat      <= '1;
            max_lat      <= '0;
            busy_cycles  <= '0;
            stall_cycles <= '0;
            err_ovf      <= 1'b0;
            err_unf      <= 1'b0;
`ifdef HLS_MON_TIMEOUT_EN
            err_timeout  <= 1'b0;
`endif
        end else if (state != ST_FINISHED) begin
            ts <= ts + CNT_W'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            txn_in_cnt   <= sat_inc(txn_in_cnt, accept);
            txn_out_cnt  <= sat_inc(txn_out_cnt, complete);
            busy_cycles  <= sat_inc(busy_cycles, ~empty);
            stall_cycles <= sat_inc(stall_cycles, stall_now);

            // The finishing cycle still records its event, but no pulse is
            // issued once the monitor is frozen.
            lat_valid <= lat_upd & ~finish;
            if (lat_upd) begin
                last_lat <= lat_new;
                if (lat_new < min_lat) min_lat <= lat_new;
                if (lat_new > max_lat) max_lat <= lat_new;
            end
            if (ovf) err_ovf <= 1'b1;
            if (unf) err_unf <= 1'b1;
`ifdef HLS_MON_TIMEOUT_EN
            if (!empty && (lat >= CNT_W'(TIMEOUT))) err_timeout <= 1'b1;
`endif

            if (finish)                   state <= ST_FINISHED;
            else if (stall_now)           state <= ST_STALL;
            else if (!empty || ap_start)  state <= ST_ACTIVE;
            else                          state <= ST_IDLE;
        end else begin
            lat_valid <= 1'b0;
        end
    end

    assign status = state;

endmodule

// File: tb/tb_hls_handshake_monitor.sv
// Self-checking bench for hls_handshake_monitor (default parameters).
// A queue-based transaction model is compared with the DUT on every falling
// edge. Hand-computed literal checks pin the model at key points.
module tb_hls_handshake_monitor;

    localparam int unsigned CNT_W = 32;
    localparam int unsigned DEPTH = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              ap_start = 1'b0;
    logic              ap_ready = 1'b0;
    logic              ap_done = 1'b0;
    logic              ap_continue = 1'b1;
    logic              finish = 1'b0;
    logic [1:0]        status;
    logic [CNT_W-1:0]  txn_in_cnt;
    logic [CNT_W-1:0]  txn_out_cnt;
    logic              lat_valid;
    logic [CNT_W-1:0]  last_lat;
    logic [CNT_W-1:0]  min_lat;
    logic [CNT_W-1:0]  max_lat;
    logic [CNT_W-1:0]  busy_cycles;
    logic [CNT_W-1:0]  stall_cycles;
    logic              err_ovf;
    logic              err_unf;
`ifdef HLS_MON_TIMEOUT_EN
    logic              err_timeout;
`endif

    always #5 clock = ~clock;

    hls_handshake_monitor #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .ap_start     (ap_start),
        .ap_ready     (ap_ready),
        .ap_done      (ap_done),
        .ap_continue  (ap_continue),
        .finish       (finish),
        .status       (status),
        .txn_in_cnt   (txn_in_cnt),
        .txn_out_cnt  (txn_out_cnt),
        .lat_valid    (lat_valid),
        .last_lat     (last_lat),
        .min_lat      (min_lat),
        .max_lat      (max_lat),
        .busy_cycles  (busy_cycles),
        .stall_cycles (stall_cycles),
        .err_ovf      (err_ovf),
        .err_unf      (err_unf)
`ifdef HLS_MON_TIMEOUT_EN
        ,
        .err_timeout  (err_timeout)
`endif
    );

    int errs = 0;
    int chks = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- transaction-level model ----------------
    logic [31:0] m_ts;
    logic [31:0] m_q[$];
    int          m_status;
    logic [31:0] m_in, m_out, m_last, m_min, m_max, m_busy, m_stall;
    logic        m_lv, m_ovf, m_unf;
    logic        m_acc, m_cmp, m_used;
    int          m_occ;
    logic [31:0] m_tmp;

    function automatic logic [31:0] sinc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic void model_reset();
        m_ts = 0; m_q.delete(); m_status = 0;
        m_in = 0; m_out = 0; m_last = 0; m_min = 32'hFFFF_FFFF; m_max = 0;
        m_busy = 0; m_stall = 0; m_lv = 0; m_ovf = 0; m_unf = 0;
    endfunction

    function automatic void record(input logic [31:0] lat);
        m_last = lat;
        m_lv   = 1'b1;
        if (lat < m_min) m_min = lat;
        if (lat > m_max) m_max = lat;
    endfunction

    initial model_reset();

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            model_reset();
        end else if (m_status != 3) begin
            m_acc  = ap_start & ap_ready;
            m_cmp  = ap_done & ap_continue;
            m_used = 1'b0;
            m_occ  = m_q.size();
            m_lv   = 1'b0;
            if (finish)                      m_status = 3;
            else if (ap_done && !ap_continue) m_status = 2;
            else if (m_occ > 0 || ap_start)  m_status = 1;
            else                             m_status = 0;
            if (m_cmp) begin
                m_out = sinc(m_out);
                if (m_q.size() > 0) begin
                    m_tmp = m_q.pop_front();
                    record(m_ts - m_tmp);
                end else if (m_acc) begin
                    record(32'd0);
                    m_used = 1'b1;
                end else begin
                    m_unf = 1'b1;
                end
            end
            if (m_acc) begin
                m_in = sinc(m_in);
                if (!m_used) begin
                    if (m_q.size() == DEPTH) m_ovf = 1'b1;
                    else m_q.push_back(m_ts);
                end
            end
            if (m_occ > 0) m_busy = sinc(m_busy);
            if (ap_done && !ap_continue) m_stall = sinc(m_stall);
            if (finish) m_lv = 1'b0;
            m_ts = m_ts + 32'd1;
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clock) begin
        if (reset) begin
            check("status", {30'd0, status}, m_status);
            check("txn_in_cnt", txn_in_cnt, m_in);
            check("txn_out_cnt", txn_out_cnt, m_out);
            check("lat_valid", {31'd0, lat_valid}, {31'd0, m_lv});
            check("last_lat", last_lat, m_last);
            check("min_lat", min_lat, m_min);
            check("max_lat", max_lat, m_max);
            check("busy_cycles", busy_cycles, m_busy);
            check("stall_cycles", stall_cycles, m_stall);
            check("err_ovf", {31'd0, err_ovf}, {31'd0, m_ovf});
            check("err_unf", {31'd0, err_unf}, {31'd0, m_unf});
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 1; finish = 0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic cyc(input logic s, input logic r, input logic d, input logic c, input logic f);
        ap_start = s; ap_ready = r; ap_done = d; ap_continue = c; finish = f;
        @(negedge clock);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [20:0] st_pat;
    logic [20:0] dn_pat;

    initial begin
        // Reset state
        do_reset();
        check("rst_status", {30'd0, status}, 32'd0);
        check("rst_min_lat", min_lat, 32'hFFFF_FFFF);
        check("rst_max_lat", max_lat, 32'd0);
        check("rst_txn_in", txn_in_cnt, 32'd0);
        check("rst_errs", {30'd0, err_ovf, err_unf}, 32'd0);

        // Single transaction, latency 7
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(1, 1, 0, 1, 0);
        repeat (6) cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 1, 1, 0);
        check("t1_lat_valid", {31'd0, lat_valid}, 32'd1);
        check("t1_last_lat", last_lat, 32'd7);
        check("t1_min_lat", min_lat, 32'd7);
        check("t1_max_lat", max_lat, 32'd7);
        check("t1_in", txn_in_cnt, 32'd1);
        check("t1_out", txn_out_cnt, 32'd1);
        check("t1_busy", busy_cycles, 32'd7);
        cyc(0, 0, 0, 1, 0);
        check("t1_pulse_end", {31'd0, lat_valid}, 32'd0);
        check("t1_idle", {30'd0, status}, 32'd0);

        // Combinational block, zero latency
        do_reset();
        cyc(1, 1, 1, 1, 0);
        check("t2_last_lat", last_lat, 32'd0);
        check("t2_lat_valid", {31'd0, lat_valid}, 32'd1);
        check("t2_in", txn_in_cnt, 32'd1);
        check("t2_out", txn_out_cnt, 32'd1);
        check("t2_unf", {31'd0, err_unf}, 32'd0);
        cyc(0, 0, 0, 1, 0);
        check("t2_busy", busy_cycles, 32'd0);
        check("t2_status", {30'd0, status}, 32'd0);

        // Pipelined: accepts 0,2,4,10; completions 5,7,9,20
        do_reset();
        st_pat = '0; dn_pat = '0;
        st_pat[0] = 1; st_pat[2] = 1; st_pat[4] = 1; st_pat[10] = 1;
        dn_pat[5] = 1; dn_pat[7] = 1; dn_pat[9] = 1; dn_pat[20] = 1;
        for (int i = 0; i < 21; i++) begin
            cyc(st_pat[i], st_pat[i], dn_pat[i], 1, 0);
            if (i == 5) check("t3_first_lat", last_lat, 32'd5);
        end
        check("t3_last_lat", last_lat, 32'd10);
        check("t3_max_lat", max_lat, 32'd10);
        check("t3_min_lat", min_lat, 32'd5);
        check("t3_in", txn_in_cnt, 32'd4);
        check("t3_out", txn_out_cnt, 32'd4);

        // Back-pressure: 3 stall cycles included in latency
        do_reset();
        cyc(1, 1, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 0, 0);
            check("t4_stall_status", {30'd0, status}, 32'd2);
        end
        cyc(0, 0, 1, 1, 0);
        check("t4_stall_cycles", stall_cycles, 32'd3);
        check("t4_last_lat", last_lat, 32'd6);
        check("t4_status", {30'd0, status}, 32'd1);

        // Errors: underflow, then overflow on the 5th accept
        do_reset();
        cyc(0, 0, 1, 1, 0);
        check("t5_unf", {31'd0, err_unf}, 32'd1);
        check("t5_out", txn_out_cnt, 32'd1);
        check("t5_last_kept", last_lat, 32'd0);
        check("t5_min_kept", min_lat, 32'hFFFF_FFFF);
        for (int k = 1; k <= 5; k++) begin
            cyc(1, 1, 0, 1, 0);
            if (k == 4) check("t5_no_ovf_yet", {31'd0, err_ovf}, 32'd0);
        end
        check("t5_ovf", {31'd0, err_ovf}, 32'd1);
        check("t5_in", txn_in_cnt, 32'd5);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        check("t5_sticky", {30'd0, err_ovf, err_unf}, 32'd3);

        // Finish freezes everything; the finishing cycle's event still counts
        do_reset();
        cyc(1, 1, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 1, 1, 1);
        check("t6_status", {30'd0, status}, 32'd3);
        check("t6_last_lat", last_lat, 32'd2);
        check("t6_lat_valid", {31'd0, lat_valid}, 32'd0);
        check("t6_busy", busy_cycles, 32'd2);
        cyc(1, 1, 0, 1, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 1, 0);
        cyc(1, 1, 1, 1, 0);
        check("t6_frozen_status", {30'd0, status}, 32'd3);
        check("t6_frozen_in", txn_in_cnt, 32'd1);
        check("t6_frozen_out", txn_out_cnt, 32'd1);
        check("t6_frozen_last", last_lat, 32'd2);
        check("t6_frozen_stall", stall_cycles, 32'd0);
        check("t6_frozen_busy", busy_cycles, 32'd2);

        // Asynchronous reset mid-operation discards outstanding entries
        do_reset();
        cyc(1, 1, 0, 1, 0);
        cyc(1, 1, 0, 1, 0);
        cyc(0, 0, 1, 1, 0);
        check("t7_pre_last", last_lat, 32'd2);
        #2 reset = 1'b0;
        #1;
        check("t7_status", {30'd0, status}, 32'd0);
        check("t7_in", txn_in_cnt, 32'd0);
        check("t7_out", txn_out_cnt, 32'd0);
        check("t7_last", last_lat, 32'd0);
        check("t7_min", min_lat, 32'hFFFF_FFFF);
        check("t7_busy", busy_cycles, 32'd0);
        check("t7_errs", {30'd0, err_ovf, err_unf}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        cyc(0, 0, 1, 1, 0);
        check("t7_fifo_empty", {31'd0, err_unf}, 32'd1);
        cyc(0, 0, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

endmodule

// File: doc/hls_handshake_monitor.md
Name: hls_handshake_monitor

Overview:
- Synthesizable status monitor for one non-dataflow HLS block-level handshake (ap_start/ap_ready/ap_done/ap_continue).
- Sits beside the DUT top in simulation or debug builds and counts accepted and completed transactions.
- Measures per-transaction latency, busy cycles and done-stall cycles, and reports a coarse module status until a finish request freezes all results.

Parameters:
- CNT_W, 32: width of the cycle timestamp, all counters and the latency outputs.
- DEPTH, 4: number of outstanding start timestamps held (power of 2, at least 2).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ap_start  in  1  monitored start.
- ap_ready  in  1  monitored ready.
- ap_done  in  1  monitored done.
- ap_continue  in  1  monitored continue; tie to 1 when the block has none.
- finish  in  1  freeze request.
- status  out  2  0=IDLE, 1=ACTIVE, 2=STALL, 3=FINISHED.
- txn_in_cnt  out  CNT_W  accepted transactions.
- txn_out_cnt  out  CNT_W  completed transactions.
- lat_valid  out  1  one-cycle pulse when last_lat updates.
- last_lat  out  CNT_W  latency of the most recent completion.
- min_lat  out  CNT_W  minimum latency seen.
- max_lat  out  CNT_W  maximum latency seen.
- busy_cycles  out  CNT_W  cycles with at least one outstanding transaction.
- stall_cycles  out  CNT_W  cycles with ap_done=1 and ap_continue=0.
- err_ovf  out  1  sticky: accept with the FIFO full.
- err_unf  out  1  sticky: completion with nothing outstanding.

Behaviour:
- Reset (reset=0, asynchronous assert):
  - status=IDLE.
  - All counters, last_lat, max_lat, lat_valid, err_ovf and err_unf = 0.
  - min_lat = all ones.
  - FIFO empty; timestamp = 0.
- Timestamp: free-running CNT_W counter, +1 per cycle, wraps.
- Latency: computed modulo 2^CNT_W as (timestamp − popped entry), which makes it wrap-safe.
- Event definitions, sampled at the rising edge:
  - accept = ap_start & ap_ready.
  - complete = ap_done & ap_continue.
- Completion path (pop before push within a cycle):
  - If complete and the FIFO is non-empty: pop the oldest timestamp, last_lat = latency, lat_valid = 1 the next cycle, update min_lat/max_lat.
  - If complete with the FIFO empty and accept in the same cycle: zero-latency transaction. last_lat = 0, lat_valid = 1, nothing is pushed.
  - If complete with the FIFO empty and no accept: set err_unf. last_lat, min_lat and max_lat are unchanged.
- Accept path (not consumed as a zero-latency transaction):
  - Push the current timestamp.
  - If the FIFO is full after the pop: drop the entry and set err_ovf.
- Counters:
  - txn_in_cnt +1 per accept.
  - txn_out_cnt +1 per complete, including underflowing completions.
  - Both saturate at 2^CNT_W−1, as do busy_cycles and stall_cycles.
- Status state machine (registered, evaluated from the current-cycle inputs and FIFO occupancy):
  - STALL when ap_done & ~ap_continue.
  - Otherwise ACTIVE when occupancy > 0 or ap_start = 1.
  - Otherwise IDLE.
- busy_cycles +1 when occupancy > 0 at the edge; stall_cycles +1 when ap_done & ~ap_continue.
- Finish:
  - finish=1 sampled at an edge → status = FINISHED from the next cycle.
  - All counters, latency registers, error flags and the FIFO then freeze; lat_valid is forced to 0.
  - FINISHED is left only by reset; finish=0 afterwards has no effect.
  - Events in the same cycle as finish are still recorded.
- Reset mid-transaction: outstanding timestamps are discarded with no error flagged.

Optional Feature:
- Macro: HLS_MON_TIMEOUT_EN.
- When defined:
  - Parameter TIMEOUT (default 1000) and output err_timeout (1 bit, sticky, reset 0) are added.
  - err_timeout sets when the oldest outstanding entry's age reaches TIMEOUT cycles.
  - err_timeout freezes on finish.
- When not defined: no TIMEOUT parameter, no err_timeout port, no associated logic.

Test Plan:
- Single transaction: start/ready at cycle 10, done with continue=1 at cycle 17 → last_lat=7, min_lat=max_lat=7, txn_in_cnt=txn_out_cnt=1, busy_cycles=7, one lat_valid pulse, status returns to IDLE.
- Combinational block: start=ready=done=continue=1 for one cycle → last_lat=0, FIFO stays empty, err_unf=0, both counts=1.
- Pipelined: accepts at cycles 0, 2, 4; completions at 5, 7, 9 → latencies 5, 5, 5; then a 4th accept at 10 completing at 20 → max_lat=10, min_lat=5.
- Back-pressure: done=1 with continue=0 for 3 cycles, then continue=1 → status=STALL for 3 cycles, stall_cycles=3, latency includes the stall.
- Errors: complete with nothing outstanding → err_unf=1; DEPTH+1 accepts with no completion → err_ovf=1 on the 5th (DEPTH=4); both stay set.
- Finish then reset: assert finish, then drive further events → status=3 and all outputs unchanged; assert reset mid-operation → all outputs return to reset values immediately (asynchronously).
